// File: rtl/axi_ad9739a_dma_fifo_pkg.sv
// Shared types and constants for the AD9739A DMA elastic buffer.
package axi_ad9739a_dma_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } fifo_state_t;

    localparam int          ADDR_WIDTH_DEF = 4;
    localparam int          DEPTH          = 2 ** ADDR_WIDTH_DEF;
    localparam logic [15:0] UNF_MAX        = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == UNF_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/axi_ad9739a_dma_fifo_if.sv
// DMA push stream and DAC core request/response signals of the elastic buffer.
interface axi_ad9739a_dma_fifo_if #(
    parameter int DATA_WIDTH = 256
);
    logic                  dac_enable;
    logic                  dac_valid;
    logic [DATA_WIDTH-1:0] dac_ddata;
    logic                  dac_dunf;
    logic                  dma_valid;
    logic [DATA_WIDTH-1:0] dma_data;
    logic                  dma_ready;

    modport master (
        output dac_enable, dac_valid, dma_valid, dma_data,
        input  dac_ddata, dac_dunf, dma_ready
    );

    modport slave (
        input  dac_enable, dac_valid, dma_valid, dma_data,
        output dac_ddata, dac_dunf, dma_ready
    );
endinterface

// File: rtl/axi_ad9739a_dma_fifo_mem.sv
// Simple dual-port word RAM: synchronous write, registered read.
module axi_ad9739a_dma_fifo_mem #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 256
) (
    input  logic                  dac_clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    // A word written into an empty FIFO lands on the address being prefetched,
    // so the read register takes the write data to keep the head word current.
    always_ff @(posedge dac_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/axi_ad9739a_dma_fifo.sv
// Elastic buffer between the DMA read stream and the AD9739A core data port.
// state | meaning
// IDLE  | disabled; pointers flushed, output word forced to zero
// FILL  | prefilling to START_LEVEL; requests answered with underflow
// RUN   | serving one word per dac_valid; empty request drops back to FILL
module axi_ad9739a_dma_fifo
    import axi_ad9739a_dma_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 256,
    parameter int START_LEVEL = 8
) (
    input  logic                  dac_clk,
    input  logic                  dac_rstn,
    axi_ad9739a_dma_fifo_if.slave bus,
    output logic [ADDR_WIDTH:0]   fifo_level,
    output logic [15:0]           unf_count
);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    fifo_state_t           state, state_nxt;
    logic [ADDR_WIDTH:0]   wptr, rptr, wptr_nxt, rptr_nxt, level_post;
    logic                  full, empty, push, pop, flush, unf_evt;
    logic                  dunf_nxt, ddata_clr, ddata_ld, dunf_q;
    logic [DATA_WIDTH-1:0] head, ddata_q;
    logic [15:0]           unf_cnt;

    assign empty      = (wptr == rptr);
    assign full       = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                        (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
    assign fifo_level = wptr - rptr;
    assign bus.dma_ready = !full && (state != IDLE);
    assign push       = bus.dma_valid && bus.dma_ready;
    assign level_post = fifo_level + {{ADDR_WIDTH{1'b0}}, push};

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        flush     = 1'b0;
        unf_evt   = 1'b0;
        dunf_nxt  = 1'b0;
        ddata_clr = 1'b0;
        ddata_ld  = 1'b0;
        if (!bus.dac_enable) begin
            state_nxt = IDLE;
            flush     = 1'b1;
            ddata_clr = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = FILL;
                    ddata_clr = 1'b1;
                end
                FILL: begin
                    if (bus.dac_valid) begin
                        ddata_clr = 1'b1;
                        dunf_nxt  = 1'b1;
                    end
                    if (int'(level_post) >= START_LEVEL) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (bus.dac_valid) begin
                        if (!empty) begin
                            pop      = 1'b1;
                            ddata_ld = 1'b1;
                        end else begin
                            ddata_clr = 1'b1;
                            dunf_nxt  = 1'b1;
                            unf_evt   = 1'b1;
                            state_nxt = FILL;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Flush wins over any push accepted on the same edge.
    assign wptr_nxt = flush ? '0 : (push ? wptr + PTR_ONE : wptr);
    assign rptr_nxt = flush ? '0 : (pop  ? rptr + PTR_ONE : rptr);

    always_ff @(posedge dac_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge dac_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            wptr    <= '0;
            rptr    <= '0;
            ddata_q <= '0;
            dunf_q  <= 1'b0;
            unf_cnt <= '0;
        end else begin
            wptr   <= wptr_nxt;
            rptr   <= rptr_nxt;
            dunf_q <= dunf_nxt;
            if (ddata_clr) begin
                ddata_q <= '0;
            end else if (ddata_ld) begin
                ddata_q <= head;
            end
            if (unf_evt) begin
                unf_cnt <= sat_inc(unf_cnt);
            end
        end
    end

    axi_ad9739a_dma_fifo_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .dac_clk (dac_clk),
        .wr_en   (push),
        .wr_addr (wptr[ADDR_WIDTH-1:0]),
        .wr_data (bus.dma_data),
        .rd_addr (rptr_nxt[ADDR_WIDTH-1:0]),
        .rd_data (head)
    );

    assign bus.dac_ddata = ddata_q;
    assign bus.dac_dunf  = dunf_q;
    assign unf_count     = unf_cnt;
endmodule

// File: tb/tb_axi_ad9739a_dma_fifo.sv
// Directed bench for the AD9739A DMA elastic buffer: vector table plus corner sequences.
module tb_axi_ad9739a_dma_fifo;
    logic        dac_clk = 1'b0;
    logic        dac_rstn;
    logic [4:0]  fifo_level;
    logic [15:0] unf_count;
    int          n_checks = 0;
    int          n_fail   = 0;

    axi_ad9739a_dma_fifo_if #(.DATA_WIDTH(256)) bus ();

    axi_ad9739a_dma_fifo #(
        .ADDR_WIDTH  (4),
        .DATA_WIDTH  (256),
        .START_LEVEL (8)
    ) dut (
        .dac_clk    (dac_clk),
        .dac_rstn   (dac_rstn),
        .bus        (bus.slave),
        .fifo_level (fifo_level),
        .unf_count  (unf_count)
    );

    always #5 dac_clk = ~dac_clk;

    typedef struct {
        logic        en;
        logic        dv;
        logic [31:0] d;
        logic        dval;
        int          lvl;
        logic        rdy;
        logic [31:0] dd;
        logic        dunf;
        int          unf;
    } vec_t;

    vec_t vecs [34];

    function automatic logic [255:0] w(input logic [31:0] x);
        return {8{x}};
    endfunction

    function automatic vec_t mk(input logic en, input logic dv, input logic [31:0] d,
                                input logic dval, input int lvl, input logic rdy,
                                input logic [31:0] dd, input logic dunf, input int unf);
        vec_t v;
        v.en = en; v.dv = dv; v.d = d; v.dval = dval;
        v.lvl = lvl; v.rdy = rdy; v.dd = dd; v.dunf = dunf; v.unf = unf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int lvl, input logic rdy,
                           input logic [31:0] dd, input logic dunf, input int unf);
        chk({nm, " level"}, 256'(fifo_level), 256'(lvl));
        chk({nm, " ready"}, 256'(bus.dma_ready), 256'(rdy));
        chk({nm, " ddata"}, bus.dac_ddata, w(dd));
        chk({nm, " dunf"},  256'(bus.dac_dunf), 256'(dunf));
        chk({nm, " unf"},   256'(unf_count), 256'(unf));
    endtask

    task automatic step(input logic en, input logic dv, input logic [31:0] d, input logic dval);
        bus.dac_enable = en;
        bus.dma_valid  = dv;
        bus.dma_data   = w(d);
        bus.dac_valid  = dval;
        @(posedge dac_clk);
        #1;
    endtask

    task automatic underflow_once(input int base, input int exp_unf);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 32'(base + k), 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            chk($sformatf("sat pop%0d data", k), bus.dac_ddata, w(32'(base + k)));
        end
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("sat dunf", 256'(bus.dac_dunf), 256'(1));
        chk("sat unf",  256'(unf_count), 256'(exp_unf));
    endtask

    initial begin
        logic [31:0] pend[$];
        logic [31:0] e;
        logic [31:0] drain [8] = '{32'h25, 32'h26, 32'h27, 32'h28,
                                   32'h29, 32'h30, 32'h31, 32'h32};

        // Basic prefill/serve/underflow, FILL-time requests, simultaneous push+pop.
        vecs[0] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 8; k++) vecs[k]     = mk(1, 1, 32'(k), 0, k, 1, 0, 0, 0);
        for (int k = 1; k <= 8; k++) vecs[8 + k] = mk(1, 0, 0, 1, 8 - k, 1, 32'(k), 0, 0);
        vecs[17] = mk(1, 0, 0, 1, 0, 1, 0, 1, 1);
        vecs[18] = mk(1, 0, 0, 0, 0, 1, 0, 0, 1);
        vecs[19] = mk(1, 1, 32'h21, 0, 1, 1, 0, 0, 1);
        vecs[20] = mk(1, 1, 32'h22, 0, 2, 1, 0, 0, 1);
        vecs[21] = mk(1, 1, 32'h23, 0, 3, 1, 0, 0, 1);
        vecs[22] = mk(1, 0, 0, 1, 3, 1, 0, 1, 1);
        vecs[23] = mk(1, 0, 0, 1, 3, 1, 0, 1, 1);
        vecs[24] = mk(1, 0, 0, 0, 3, 1, 0, 0, 1);
        for (int k = 0; k < 5; k++) vecs[25 + k] = mk(1, 1, 32'(32'h24 + k), 0, 4 + k, 1, 0, 0, 1);
        vecs[30] = mk(1, 0, 0, 1, 7, 1, 32'h21, 0, 1);
        vecs[31] = mk(1, 0, 0, 1, 6, 1, 32'h22, 0, 1);
        vecs[32] = mk(1, 1, 32'h29, 1, 6, 1, 32'h23, 0, 1);
        vecs[33] = mk(1, 0, 0, 0, 6, 1, 32'h23, 0, 1);

        bus.dac_enable = 1'b0;
        bus.dac_valid  = 1'b0;
        bus.dma_valid  = 1'b0;
        bus.dma_data   = '0;
        dac_rstn       = 1'b0;
        #23;
        chk_all("reset", 0, 0, 0, 0, 0);
        dac_rstn = 1'b1;
        @(posedge dac_clk);
        #1;
        step(1'b0, 1'b1, 32'hDEAD, 1'b1);
        chk_all("idle", 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].dv, vecs[i].d, vecs[i].dval);
            chk_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].rdy, vecs[i].dd,
                    vecs[i].dunf, vecs[i].unf);
        end

        // Fill to full; push is blocked on the pop cycle, then accepted.
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 32'(32'h30 + k), 1'b0);
        chk_all("full", 16, 0, 32'h23, 0, 1);
        step(1'b1, 1'b1, 32'h3A, 1'b1);
        chk_all("full pop", 15, 1, 32'h24, 0, 1);
        step(1'b1, 1'b1, 32'h3B, 1'b0);
        chk_all("refull", 16, 0, 32'h24, 0, 1);

        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            chk($sformatf("drain%0d", k), bus.dac_ddata, w(drain[k]));
        end
        chk("drain level", 256'(fifo_level), 256'(8));

        // Steady stream at level 8 across several pointer wraps.
        pend = '{32'h33, 32'h34, 32'h35, 32'h36, 32'h37, 32'h38, 32'h39, 32'h3B};
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b1, 32'(32'h100 + i), 1'b1);
            pend.push_back(32'(32'h100 + i));
            e = pend.pop_front();
            chk($sformatf("stream%0d data", i), bus.dac_ddata, w(e));
            chk($sformatf("stream%0d level", i), 256'(fifo_level), 256'(8));
            chk($sformatf("stream%0d dunf", i), 256'(bus.dac_dunf), 256'(0));
        end

        // Disable mid-RUN at level 10 with a push in flight.
        step(1'b1, 1'b1, 32'h200, 1'b0);
        step(1'b1, 1'b1, 32'h201, 1'b0);
        chk("lvl10", 256'(fifo_level), 256'(10));
        step(1'b0, 1'b1, 32'h202, 1'b1);
        chk_all("disable", 0, 0, 0, 0, 1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk_all("disabled req", 0, 0, 0, 0, 1);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk_all("reenable", 0, 1, 0, 0, 1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk_all("reenable fill", 0, 1, 0, 1, 1);

        // Saturation: preload the counter near the top, then real underflows.
        force dut.unf_cnt = 16'hFFFD;
        #2;
        release dut.unf_cnt;
        underflow_once(32'h300, 32'hFFFE);
        underflow_once(32'h310, 32'hFFFF);
        underflow_once(32'h320, 32'hFFFF);

        // Async reset between edges while serving data.
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 32'(32'h400 + k), 1'b0);
        step(1'b1, 1'b1, 32'h408, 1'b1);
        chk("pre-reset data", bus.dac_ddata, w(32'h400));
        #3;
        dac_rstn = 1'b0;
        #1;
        chk_all("async reset", 0, 0, 0, 0, 0);
        #2;
        dac_rstn = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
